debounce_multi: RTL and testbench
=================================

# debounce_multi

Parametrised multi-channel debouncer for mechanical switch and button inputs. Each channel synchronises its raw asynchronous input, times how long the new level stays stable with a per-channel counter, and commits the level to a clean output only after a full stable interval. Optional single-cycle edge pulses are available. The block sits between the board I/O pins and the control FSMs, and replaces the single-channel, fixed-width debounce chain.

## Interface
- `N_CH`, default 4: number of independent channels (1..32).
- `CNT_W`, default 6: stability counter width; the stable interval is 2^CNT_W cycles (2..24).
- `SYNC_STAGES`, default 2: synchroniser flops per channel (2..4).
- `clk` input, 1 bit: single clock for all logic.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `sig_in` input, N_CH bits: raw asynchronous switch levels.
- `ch_en` input, N_CH bits: per-channel enable.
- `db_out` output, N_CH bits: debounced levels.
- `rise_pulse` output, N_CH bits: one-cycle pulse when `db_out[i]` goes 0→1.
- `fall_pulse` output, N_CH bits: one-cycle pulse when `db_out[i]` goes 1→0.
- `busy` output, N_CH bits: high while channel i is timing a candidate change.

## Operation
- Each channel is independent. There is no shared counter and no arbitration between channels.
- `sync_q[i]` is the output of the SYNC_STAGES flop chain on `sig_in[i]`. All decisions use `sync_q` only.
- Per-channel FSM, two states: IDLE and COUNT. Counter `cnt` is CNT_W bits. MAX = 2^CNT_W−1.
- IDLE transitions:
  - If `ch_en` is high and `sync_q != db_out`: go to COUNT, set `cnt <= 1`.
  - Otherwise: stay in IDLE with `cnt = 0`.
- COUNT transitions (first matching condition wins):
  1. `ch_en` low: go to IDLE, `cnt <= 0`. `db_out` holds its value.
  2. `sync_q == db_out` (bounce back): go to IDLE, `cnt <= 0`. No output change, no pulse.
  3. `cnt == MAX`: `db_out <= sync_q`, fire the matching pulse, go to IDLE, `cnt <= 0`.
  4. Otherwise: `cnt <= cnt + 1`. The counter never wraps, because case 3 catches MAX first.
- `busy[i]` is high exactly when channel i is in COUNT.
- A disabled channel keeps `db_out` frozen and still updates its synchroniser. When re-enabled, it starts a fresh interval from `cnt = 1` if `sync_q` differs from `db_out`.
- Reset mid-count discards the count. No pulse is emitted.

## Timing
- Reset values: `db_out` = 0, `rise_pulse` = 0, `fall_pulse` = 0, `busy` = 0, `cnt` = 0, all sync flops = 0, FSM = IDLE.
- Latency: take edge 0 as the first `clk` edge that samples a new stable `sig_in` level. Then:
  - `db_out` changes on edge SYNC_STAGES + 2^CNT_W − 1. With defaults, that is edge 65.
  - The pulse is high for exactly the one cycle following that same edge.
  - `busy` rises on edge SYNC_STAGES and falls on the same edge as the `db_out` update.
- A glitch is rejected if `sync_q` returns to the old level at any edge up to and including edge SYNC_STAGES + 2^CNT_W − 2.
- At most one of `rise_pulse[i]` / `fall_pulse[i]` is high in any cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `DEBOUNCE_EDGE_EN` defined: `rise_pulse` / `fall_pulse` are generated as described above.
- `DEBOUNCE_EDGE_EN` undefined: the pulse logic is removed and both ports are tied to 0. The ports stay present. `db_out` and `busy` behaviour is identical in both builds.

## Structure
- Shared package `debounce_pkg`:
  - FSM state typedef (IDLE, COUNT).
  - Parameter range limits (N_CH_MAX = 32, CNT_W_MIN = 2, CNT_W_MAX = 24, SYNC_MIN = 2, SYNC_MAX = 4).
- Sub-module `debounce_channel`: one synchroniser, FSM, counter and pulse logic, parameterised by CNT_W and SYNC_STAGES.
- `debounce_multi` instantiates N_CH copies of `debounce_channel` in a generate loop and checks parameter ranges at elaboration.

## Test plan
- Reset check: assert `reset` with random `sig_in` → every output is 0. Release `reset` with `sig_in` = 0 → outputs stay 0, `busy` stays 0.
- Clean press, defaults, ch0: `sig_in[0]` goes 0→1 before edge 0 and stays high → `busy[0]` is high from edge 2, `db_out[0]` = 1 at edge 65, `rise_pulse[0]` is high for one cycle, `busy[0]` drops at edge 65.
- Bounce rejection: `sig_in[0]` high for 40 cycles then low → `db_out[0]` stays 0, no pulse, `busy[0]` high then low. Same test with a 63-cycle-stable pulse → also rejected.
- Parallel channels: ch1 rises at cycle 0 and ch2 falls (from a settled 1) at cycle 10 → `rise_pulse[1]` after edge 65 and `fall_pulse[2]` after edge 75, with no cross-channel interaction.
- Enable and reset mid-count: drop `ch_en[3]` at cnt = 30 → `busy[3]` drops next edge and `db_out[3]` is unchanged. Re-enable → full 64-cycle interval again. Assert `reset` at cnt = 50 → every output is 0 immediately.
- Build without `DEBOUNCE_EDGE_EN`, repeating the clean-press test → `db_out` timing is identical and both pulse buses stay 0.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and parameter limits for the multi-channel debouncer.
// Imported by debounce_channel and debounce_multi.
package debounce_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_COUNT = 1'b1
   } db_state_e;

   localparam int N_CH_MAX  = 32;
   localparam int CNT_W_MIN = 2;
   localparam int CNT_W_MAX = 24;
   localparam int SYNC_MIN  = 2;
   localparam int SYNC_MAX  = 4;

endpackage

// File: rtl/debounce_if.sv
// Bundle of the per-channel switch inputs and debounced outputs.
// Ports: sig_in, ch_en (to block); db_out, rise_pulse, fall_pulse, busy (from block).
interface debounce_if #(
   parameter int N_CH = 4
);

   logic [N_CH-1:0] sig_in;
   logic [N_CH-1:0] ch_en;
   logic [N_CH-1:0] db_out;
   logic [N_CH-1:0] rise_pulse;
   logic [N_CH-1:0] fall_pulse;
   logic [N_CH-1:0] busy;

   modport master (
      output sig_in,
      output ch_en,
      input  db_out,
      input  rise_pulse,
      input  fall_pulse,
      input  busy
   );

   modport slave (
      input  sig_in,
      input  ch_en,
      output db_out,
      output rise_pulse,
      output fall_pulse,
      output busy
   );

endinterface

// File: rtl/debounce_channel.sv
// One debounce channel: synchroniser, IDLE/COUNT FSM, stability counter, edge pulses.
// Ports: clk, reset (async high), i_sig, i_en -> o_db, o_rise, o_fall, o_busy.
// Macro DEBOUNCE_EDGE_EN enables the pulse registers; otherwise pulses are tied 0.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int CNT_W       = 6,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_sig,
   input  logic i_en,
   output logic o_db,
   output logic o_rise,
   output logic o_fall,
   output logic o_busy
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [SYNC_STAGES-1:0] r_sync;
   db_state_e              r_state;
   db_state_e              w_state_nxt;
   logic [CNT_W-1:0]       r_cnt;
   logic [CNT_W-1:0]       w_cnt_nxt;
   logic                   r_db;
   logic                   w_db_nxt;
   logic                   w_sync_q;
   logic                   w_commit;

   assign w_sync_q = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync  <= '0;
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_db    <= 1'b0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], i_sig};
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_db    <= w_db_nxt;
      end
   end

   // Counter is zero whenever the FSM lands in IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      w_db_nxt    = r_db;
      w_commit    = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (i_en && (w_sync_q != r_db)) begin
               w_state_nxt = ST_COUNT;
               w_cnt_nxt   = CNT_ONE;
            end
         end
         ST_COUNT: begin
            if (!i_en) begin
               w_state_nxt = ST_IDLE;
            end else if (w_sync_q == r_db) begin
               w_state_nxt = ST_IDLE;
            end else if (r_cnt == CNT_MAX) begin
               w_state_nxt = ST_IDLE;
               w_db_nxt    = w_sync_q;
               w_commit    = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_ONE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign o_db   = r_db;
   assign o_busy = (r_state == ST_COUNT);

`ifdef DEBOUNCE_EDGE_EN
   logic r_rise;
   logic r_fall;

   // The committed level is the new level, so it selects the pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_rise <= w_commit & w_sync_q;
         r_fall <= w_commit & ~w_sync_q;
      end
   end

   assign o_rise = r_rise;
   assign o_fall = r_fall;
`else
   logic w_unused_commit;
   assign w_unused_commit = w_commit;
   assign o_rise = 1'b0;
   assign o_fall = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// N_CH independent switch debouncers; replaces the single-channel debounce chain.
// Ports: clk, reset (async high), bus (debounce_if.slave). Macro: DEBOUNCE_EDGE_EN.
module debounce_multi
   import debounce_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int CNT_W       = 6,
   parameter int SYNC_STAGES = 2
) (
   input  logic      clk,
   input  logic      reset,
   debounce_if.slave bus
);

   if (N_CH < 1 || N_CH > N_CH_MAX) begin : g_bad_nch
      $error("debounce_multi: N_CH out of range");
   end
   if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cntw
      $error("debounce_multi: CNT_W out of range");
   end
   if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
      $error("debounce_multi: SYNC_STAGES out of range");
   end

   logic [N_CH-1:0] w_db;
   logic [N_CH-1:0] w_rise;
   logic [N_CH-1:0] w_fall;
   logic [N_CH-1:0] w_busy;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      debounce_channel #(
         .CNT_W       (CNT_W),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_ch (
         .clk    (clk),
         .reset  (reset),
         .i_sig  (bus.sig_in[g]),
         .i_en   (bus.ch_en[g]),
         .o_db   (w_db[g]),
         .o_rise (w_rise[g]),
         .o_fall (w_fall[g]),
         .o_busy (w_busy[g])
      );
   end

   assign bus.db_out     = w_db;
   assign bus.rise_pulse = w_rise;
   assign bus.fall_pulse = w_fall;
   assign bus.busy       = w_busy;

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi: directed timing scenarios plus
// randomized switch activity compared against a stable-run-length reference model.
module tb_debounce_multi;

   localparam int N      = 4;
   localparam int CW     = 6;
   localparam int SS     = 2;
   localparam int STABLE = 1 << CW;
   localparam int UPD    = SS + STABLE - 1;
`ifdef DEBOUNCE_EDGE_EN
   localparam bit EDGE = 1'b1;
`else
   localparam bit EDGE = 1'b0;
`endif

   logic clk;
   logic reset;

   debounce_if #(.N_CH(N)) bus ();

   debounce_multi #(
      .N_CH        (N),
      .CNT_W       (CW),
      .SYNC_STAGES (SS)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [SS-1:0] m_sync [N];
   int            m_run  [N];
   logic [N-1:0]  m_db;
   logic [N-1:0]  m_rise;
   logic [N-1:0]  m_fall;
   logic [N-1:0]  m_busy;
   logic [N-1:0]  cur_sig;
   logic [N-1:0]  cur_en;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_sync[i] = '0;
         m_run[i]  = 0;
      end
      m_db   = '0;
      m_rise = '0;
      m_fall = '0;
      m_busy = '0;
   endtask

   // A level commits once it has differed from the output, with the
   // channel enabled, for STABLE consecutive clock edges.
   task automatic model_step(input logic [N-1:0] s, input logic [N-1:0] e);
      for (int i = 0; i < N; i++) begin
         logic q;
         q = m_sync[i][SS-1];
         m_rise[i] = 1'b0;
         m_fall[i] = 1'b0;
         if (e[i] && (q != m_db[i])) begin
            m_run[i]++;
            if (m_run[i] == STABLE) begin
               m_rise[i] = q;
               m_fall[i] = ~q;
               m_db[i]   = q;
               m_run[i]  = 0;
            end
         end else begin
            m_run[i] = 0;
         end
         m_busy[i] = (m_run[i] != 0);
         m_sync[i] = {m_sync[i][SS-2:0], s[i]};
      end
   endtask

   // Called at a negedge: drive, clock once, compare against the model.
   task automatic cyc();
      bus.sig_in = cur_sig;
      bus.ch_en  = cur_en;
      @(posedge clk);
      model_step(cur_sig, cur_en);
      @(negedge clk);
      chk("db", bus.db_out, m_db);
      chk("busy", bus.busy, m_busy);
      chk("rise", bus.rise_pulse, EDGE ? m_rise : '0);
      chk("fall", bus.fall_pulse, EDGE ? m_fall : '0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_db"}, bus.db_out, '0);
      chk({tag, "_busy"}, bus.busy, '0);
      chk({tag, "_rise"}, bus.rise_pulse, '0);
      chk({tag, "_fall"}, bus.fall_pulse, '0);
   endtask

   initial begin
      int thr;
      reset      = 1'b1;
      cur_sig    = N'($urandom);
      cur_en     = '1;
      bus.sig_in = cur_sig;
      bus.ch_en  = cur_en;
      model_reset();

      // reset with random inputs
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         cur_sig    = N'($urandom);
         bus.sig_in = cur_sig;
         chk_zero("rst");
      end
      reset   = 1'b0;
      cur_sig = '0;
      for (int k = 0; k < 10; k++) begin
         cyc();
         chk("idle_busy", bus.busy, '0);
      end

      // bounce rejection: 40 and 63 cycles high
      for (int w = 0; w < 2; w++) begin
         int len;
         len = (w == 0) ? 40 : 63;
         for (int k = 0; k < 100; k++) begin
            cur_sig[0] = (k < len);
            cyc();
            chk("bnc_db", bus.db_out[0], 1'b0);
            chk("bnc_rise", bus.rise_pulse[0], 1'b0);
            if (k == 30)
               chk("bnc_busy", bus.busy[0], 1'b1);
         end
         chk("bnc_busy_end", bus.busy[0], 1'b0);
      end

      // clean press on ch0
      for (int k = 0; k <= UPD + 3; k++) begin
         cur_sig[0] = 1'b1;
         cyc();
         chk("cp_busy", bus.busy[0], (k >= SS && k < UPD));
         chk("cp_db", bus.db_out[0], (k >= UPD));
         chk("cp_rise", bus.rise_pulse[0], EDGE && (k == UPD));
      end

      // settle ch2 high, then parallel ch1 rise / ch2 fall
      cur_sig[2] = 1'b1;
      for (int k = 0; k < 70; k++) cyc();
      chk("par_pre", bus.db_out[2], 1'b1);
      for (int k = 0; k <= UPD + 15; k++) begin
         cur_sig[1] = 1'b1;
         if (k >= 10) cur_sig[2] = 1'b0;
         cyc();
         chk("par_db1", bus.db_out[1], (k >= UPD));
         chk("par_db2", bus.db_out[2], (k < UPD + 10));
         chk("par_rise1", bus.rise_pulse[1], EDGE && (k == UPD));
         chk("par_fall2", bus.fall_pulse[2], EDGE && (k == UPD + 10));
         chk("par_x", {bus.rise_pulse[2], bus.fall_pulse[1]}, 2'b00);
      end

      // enable drop at cnt=30, re-enable later
      for (int k = 0; k <= 105; k++) begin
         cur_sig[3] = 1'b1;
         cur_en[3]  = !(k >= 32 && k < 40);
         cyc();
         if (k == 31) chk("en_busy31", bus.busy[3], 1'b1);
         if (k == 32) chk("en_busy32", bus.busy[3], 1'b0);
         chk("en_db", bus.db_out[3], (k >= 40 + STABLE - 1));
      end

      // reset mid-count at cnt=50
      cur_sig[3] = 1'b0;
      for (int k = 0; k < 52; k++) cyc();
      chk("mr_busy", bus.busy[3], 1'b1);
      reset = 1'b1;
      #1;
      chk_zero("mrst");
      model_reset();
      @(negedge clk);
      chk_zero("mrst2");
      reset = 1'b0;

      // randomized activity
      for (int ph = 0; ph < 6; ph++) begin
         thr = (ph % 3 == 0) ? 4 : ((ph % 3 == 1) ? 12 : 40);
         for (int k = 0; k < 500; k++) begin
            for (int i = 0; i < N; i++) begin
               if ($urandom_range(0, 999) < thr) cur_sig[i] = ~cur_sig[i];
               if ($urandom_range(0, 999) < 3) cur_en[i] = ~cur_en[i];
            end
            cyc();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
